// File: rtl/control_sequencer.sv
// Eight-phase control sequencer for a simple accumulator CPU, with a sticky halt.
// Optional instruction counter output enabled by defining CTRL_INSTR_CNT_EN.
package control_sequencer_pkg;
  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;
endpackage

module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  opcode,
  input  logic        zero,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        load_ir,
  output logic        load_ac,
  output logic        inc_pc,
  output logic        load_pc,
  output logic        halt,
`ifdef CTRL_INSTR_CNT_EN
  output logic [15:0] instr_cnt,
`endif
  output logic [2:0]  phase
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  phase_t  state_q, state_d;
  logic    halted_q, halted_d;
  opcode_t op;
  logic    alu_op;

  assign op     = opcode_t'(opcode);
  assign alu_op = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  assign phase  = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    load_ir  = 1'b0;
    load_ac  = 1'b0;
    inc_pc   = 1'b0;
    load_pc  = 1'b0;
    halt     = 1'b0;
    if (halted_q) begin
      // Frozen in OP_ADDR; only rst leaves this condition.
      halt = 1'b1;
    end else begin
      case (state_q)
        INST_ADDR: begin
          state_d = INST_FETCH;
        end
        INST_FETCH: begin
          mem_rd  = 1'b1;
          state_d = INST_LOAD;
        end
        INST_LOAD: begin
          mem_rd  = 1'b1;
          load_ir = 1'b1;
          state_d = IDLE;
        end
        IDLE: begin
          mem_rd  = 1'b1;
          load_ir = 1'b1;
          state_d = OP_ADDR;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          if (op == HLT) begin
            halt     = 1'b1;
            halted_d = 1'b1;
            state_d  = OP_ADDR;
          end else begin
            state_d = OP_FETCH;
          end
        end
        OP_FETCH: begin
          mem_rd  = alu_op;
          state_d = ALU_OP;
        end
        ALU_OP: begin
          mem_rd  = alu_op;
          load_ac = alu_op;
          inc_pc  = (op == SKZ) && zero;
          load_pc = (op == JMP);
          state_d = STORE;
        end
        STORE: begin
          mem_rd  = alu_op;
          load_ac = alu_op;
          inc_pc  = (op == JMP);
          load_pc = (op == JMP);
          mem_wr  = (op == STO);
          state_d = INST_ADDR;
        end
        default: begin
          state_d = INST_ADDR;
        end
      endcase
    end
  end

`ifdef CTRL_INSTR_CNT_EN
  logic [15:0] cnt_q;

  // Counts completed instructions on the STORE->INST_ADDR wrap; a halted
  // sequencer never reaches STORE, so the count holds while halted.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'h0000;
    end else if (!halted_q && (state_q == STORE)) begin
      cnt_q <= cnt_q + 16'h0001;
    end
  end

  assign instr_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-phase strobe table plus halt/reset sequences.
module tb_control_sequencer;

  logic        clk;
  logic        rst;
  logic [2:0]  opcode;
  logic        zero;
  logic        mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, halt;
  logic [2:0]  phase;
`ifdef CTRL_INSTR_CNT_EN
  logic [15:0] instr_cnt;
`endif

  control_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .zero      (zero),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .load_ir   (load_ir),
    .load_ac   (load_ac),
    .inc_pc    (inc_pc),
    .load_pc   (load_pc),
    .halt      (halt),
`ifdef CTRL_INSTR_CNT_EN
    .instr_cnt (instr_cnt),
`endif
    .phase     (phase)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic       z;
    logic [2:0] ph;
    logic [6:0] strb;  // {mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, halt}
  } row_t;

  localparam int MAX_ROWS = 96;
  row_t rows[MAX_ROWS];
  int   n_rows;
  int   n_checks;
  int   n_fail;

  function automatic logic [6:0] strobes();
    return {mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, halt};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // One instruction = 8 rows; patterns are bit p = value in phase p.
  task automatic add_instr(input logic [2:0] op, input logic z,
                           input logic [7:0] md, input logic [7:0] mw,
                           input logic [7:0] la, input logic [7:0] ip,
                           input logic [7:0] lp);
    logic [7:0] ir;
    ir = 8'b0000_1100;
    for (int p = 0; p < 8; p++) begin
      rows[n_rows].op   = op;
      rows[n_rows].z    = z;
      rows[n_rows].ph   = 3'(p);
      rows[n_rows].strb = {md[p], mw[p], ir[p], la[p], ip[p], lp[p], 1'b0};
      n_rows++;
    end
  endtask

  // driver: reset spans one posedge and returns at a negedge
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_rows   = 0;
    rst      = 1'b1;
    opcode   = 3'd2;
    zero     = 1'b0;

    //            op    z     mem_rd        mem_wr        load_ac       inc_pc        load_pc
    add_instr(3'd2, 1'b0, 8'b1110_1110, 8'b0000_0000, 8'b1100_0000, 8'b0001_0000, 8'b0000_0000); // ADD
    add_instr(3'd2, 1'b1, 8'b1110_1110, 8'b0000_0000, 8'b1100_0000, 8'b0001_0000, 8'b0000_0000); // ADD z=1
    add_instr(3'd6, 1'b0, 8'b0000_1110, 8'b1000_0000, 8'b0000_0000, 8'b0001_0000, 8'b0000_0000); // STO
    add_instr(3'd1, 1'b1, 8'b0000_1110, 8'b0000_0000, 8'b0000_0000, 8'b0101_0000, 8'b0000_0000); // SKZ z=1
    add_instr(3'd1, 1'b0, 8'b0000_1110, 8'b0000_0000, 8'b0000_0000, 8'b0001_0000, 8'b0000_0000); // SKZ z=0
    add_instr(3'd7, 1'b0, 8'b0000_1110, 8'b0000_0000, 8'b0000_0000, 8'b1001_0000, 8'b1100_0000); // JMP
    add_instr(3'd3, 1'b0, 8'b1110_1110, 8'b0000_0000, 8'b1100_0000, 8'b0001_0000, 8'b0000_0000); // AND
    add_instr(3'd4, 1'b1, 8'b1110_1110, 8'b0000_0000, 8'b1100_0000, 8'b0001_0000, 8'b0000_0000); // XOR
    add_instr(3'd5, 1'b0, 8'b1110_1110, 8'b0000_0000, 8'b1100_0000, 8'b0001_0000, 8'b0000_0000); // LDA
    add_instr(3'd6, 1'b1, 8'b0000_1110, 8'b1000_0000, 8'b0000_0000, 8'b0001_0000, 8'b0000_0000); // STO z=1
    add_instr(3'd7, 1'b1, 8'b0000_1110, 8'b0000_0000, 8'b0000_0000, 8'b1001_0000, 8'b1100_0000); // JMP z=1

    // reset state
    do_reset();
    #1;
    check("reset_phase", 16'(phase), 16'd0);
    check("reset_strobes", 16'(strobes()), 16'd0);

    // rst held: phase stays 0
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      #1;
      check("rst_held_phase", 16'(phase), 16'd0);
    end
    rst = 1'b0;

    // table-driven instruction sweep; row 0 is the first cycle after reset release
    do_reset();
    for (int i = 0; i < n_rows; i++) begin
      opcode = rows[i].op;
      zero   = rows[i].z;
      #1;
      check($sformatf("row%0d_phase", i), 16'(phase), 16'(rows[i].ph));
      check($sformatf("row%0d_strobes", i), 16'(strobes()), 16'(rows[i].strb));
      check("rd_wr_exclusive", 16'(mem_rd & mem_wr), 16'd0);
      step();
    end

    // reset mid-instruction at phase 5
    do_reset();
    opcode = 3'd2;
    zero   = 1'b0;
    for (int i = 0; i < 5; i++) step();
    #1;
    check("mid_pre_phase", 16'(phase), 16'd5);
    do_reset();
    #1;
    check("mid_post_phase", 16'(phase), 16'd0);
    check("mid_post_strobes", 16'(strobes()), 16'd0);

    // halt entry and hold
    opcode = 3'd0;
    for (int i = 0; i < 4; i++) step();
    #1;
    check("hlt_entry_phase", 16'(phase), 16'd4);
    check("hlt_entry_strobes", 16'(strobes()), 16'b0000101);
    for (int i = 0; i < 22; i++) begin
      step();
      opcode = 3'($urandom_range(0, 7));
      zero   = 1'($urandom_range(0, 1));
      #1;
      check("halted_phase", 16'(phase), 16'd4);
      check("halted_strobes", 16'(strobes()), 16'b0000001);
    end
    opcode = 3'd2;
    do_reset();
    #1;
    check("hlt_reset_phase", 16'(phase), 16'd0);
    check("hlt_reset_strobes", 16'(strobes()), 16'd0);
    step();
    #1;
    check("hlt_resume_phase", 16'(phase), 16'd1);

`ifdef CTRL_INSTR_CNT_EN
    // three full ADD instructions
    do_reset();
    opcode = 3'd2;
    #1;
    check("cnt_reset", instr_cnt, 16'd0);
    for (int i = 0; i < 24; i++) step();
    #1;
    check("cnt_three", instr_cnt, 16'd3);
    // preload to 0xFFFF at phase 0, one instruction later it wraps
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    check("cnt_preload", instr_cnt, 16'hFFFF);
    for (int i = 0; i < 8; i++) step();
    #1;
    check("cnt_wrap", instr_cnt, 16'h0000);
    // halted: count frozen
    opcode = 3'd0;
    for (int i = 0; i < 12; i++) step();
    #1;
    check("cnt_halted", instr_cnt, 16'h0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 No parameters; opcode encoding SHALL come from the shared typedefs package: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 opcode  input  3  instruction register opcode field; valid from phase IDLE onward.
REQ-005 zero  input  1  accumulator-zero flag from the ALU.
REQ-006 mem_rd  output  1  memory read strobe.
REQ-007 mem_wr  output  1  memory write strobe.
REQ-008 load_ir  output  1  instruction register load enable.
REQ-009 load_ac  output  1  accumulator load enable.
REQ-010 inc_pc  output  1  program counter increment.
REQ-011 load_pc  output  1  program counter load from operand.
REQ-012 halt  output  1  processor halted indication.
REQ-013 phase  output  3  current phase number, 0..7.

Function
REQ-014 An internal 3-bit phase counter SHALL step INST_ADDR(0), INST_FETCH(1), INST_LOAD(2), IDLE(3), OP_ADDR(4), OP_FETCH(5), ALU_OP(6), STORE(7), then wrap 7->0, one phase per clk.
REQ-015 Each instruction SHALL take exactly 8 cycles, with no stalls except halt.
REQ-016 The strobe outputs SHALL be combinational functions of phase, opcode, zero and the halted flag; ALUOP below means opcode in {ADD, AND, XOR, LDA}.
REQ-017 INST_ADDR: all strobes 0.
REQ-018 INST_FETCH: mem_rd=1.
REQ-019 INST_LOAD and IDLE: mem_rd=1 and load_ir=1.
REQ-020 OP_ADDR: inc_pc=1; halt=1 if opcode==HLT.
REQ-021 OP_FETCH: mem_rd=ALUOP.
REQ-022 ALU_OP: mem_rd=ALUOP, load_ac=ALUOP, inc_pc=(opcode==SKZ && zero), load_pc=(opcode==JMP).
REQ-023 STORE: mem_rd=ALUOP, load_ac=ALUOP, inc_pc=(opcode==JMP), load_pc=(opcode==JMP), mem_wr=(opcode==STO).
REQ-024 Halt entry: in OP_ADDR with opcode==HLT, the registered halted flag SHALL set at the next posedge, and phase SHALL freeze at 4.
REQ-025 While halted: halt=1, every other strobe 0, and phase held at 4 regardless of opcode or zero changes.
REQ-026 Only rst SHALL leave the halted condition.
REQ-027 mem_rd and mem_wr SHALL never both be 1 in the same cycle.
REQ-028 load_pc=1 SHALL occur only when opcode==JMP.

Reset
REQ-029 When rst=1 at a posedge, phase SHALL become 0 and halted SHALL clear, taking priority over all other events, including reset mid-instruction and reset while halted.
REQ-030 In the cycle after reset, all strobes SHALL be 0 and halt=0.
REQ-031 While rst is held, phase SHALL stay 0.

Configuration
REQ-032 Macro CTRL_INSTR_CNT_EN, when defined, SHALL add output instr_cnt [15:0].
REQ-033 instr_cnt SHALL be cleared by rst and SHALL increment at each STORE->INST_ADDR wrap.
REQ-034 instr_cnt SHALL wrap 0xFFFF->0x0000 and SHALL not change while halted.
REQ-035 When CTRL_INSTR_CNT_EN is undefined, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-036 Reset then opcode=ADD held -> phase 0..7 repeating; mem_rd pattern 0,1,1,1,0,1,1,1; load_ac=1 in phases 6,7 only; inc_pc=1 in phase 4 only.
REQ-037 opcode=STO -> mem_wr=1 only in phase 7; mem_rd=0 in phases 5..7; load_ac never 1.
REQ-038 opcode=SKZ with zero=1 -> inc_pc=1 in phases 4 and 6; with zero=0 -> inc_pc=1 in phase 4 only.
REQ-039 opcode=JMP -> load_pc=1 in phases 6,7; inc_pc=1 in phases 4,7.
REQ-040 opcode=HLT -> halt=1 from phase 4 onward, phase stuck at 4 for 20+ cycles with all strobes 0; rst=1 for one cycle -> phase=0, halt=0.
REQ-041 rst asserted at phase 5 -> phase=0 next cycle; with CTRL_INSTR_CNT_EN, 3 full ADD instructions -> instr_cnt=3, and preloaded 0xFFFF -> 0x0000 after the next instruction.
